kronos_ex_sequencer: RTL
========================

Name: kronos_ex_sequencer

Overview:
Parametrised execution-stage sequencer for the Kronos core. It generalises the fixed LSU/CSR sequencing to NUM_MC multi-cycle functional units, for example LSU, CSR, MUL and DIV. It gates instruction validity, generates decode_rdy, drives trap activation and return, and waits for WFI. It also logs trap-event PCs into a depth-configurable FIFO that a debug/trace port drains.

Parameters:
NUM_MC, 3, number of multi-cycle functional units (1..8)
FENCE_DRAIN, 1, when 1 a FENCE holds until stbuf_empty
TRAP_LOG_DEPTH, 4, trap-PC log FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rstz  in  1  async active-low reset
decode_vld  in  1  ID/EX instruction valid
decode_rdy  out  1  instruction consumed this cycle
decode_pc  in  32  PC of the presented instruction
dec_basic  in  1  single-cycle ALU/jump/fence class
dec_fence  in  1  FENCE instruction
dec_mc_sel  in  NUM_MC  one-hot select of multi-cycle unit
dec_system  in  1  system instruction
dec_sysop  in  2  sysop code (ECALL, EBREAK, MRET, WFI; kronos_types encoding)
exception  in  1  decode exception (illegal or misaligned)
core_interrupt  in  1  pending enabled interrupt
stbuf_empty  in  1  store buffer drained
mc_vld  out  NUM_MC  per-unit request valid
mc_rdy  in  NUM_MC  per-unit completion
instr_vld  out  1  instruction executable this cycle
activate_trap  out  1  state==TRAP
return_trap  out  1  state==RETURN
trap_jump  in  1  CSR unit redirect to trap handler / mepc
instret  out  1  registered instruction-retired pulse
exec_pc  out  32  PC of the last accepted instruction
trap_log_vld  out  1  log FIFO non-empty
trap_log_rdy  in  1  consumer pop
trap_log_pc  out  32  head entry
trap_log_ovf  out  1  sticky overflow flag
trap_log_clr  in  1  clears trap_log_ovf

Behaviour:
- States: STEADY, MC, TRAP, RETURN, WFINTR, JUMP. A registered mc_idx (clog2(NUM_MC) bits) holds the busy unit.
- Priority encoding of dec_mc_sel: if more than one bit is set, the lowest index wins for mc_vld, mc_idx and completion.
- instr_vld = decode_vld & state==STEADY & ~exception & ~core_interrupt.
- fence_hold = FENCE_DRAIN & dec_fence & instr_vld & ~stbuf_empty.
- mc_vld[i] = (instr_vld & sel==i) | (state==MC & mc_idx==i).
- decode_rdy = (instr_vld & dec_basic & ~fence_hold) | OR over i of (mc_vld[i] & mc_rdy[i]).
- Transitions from STEADY, evaluated only when decode_vld, in priority order:
  - core_interrupt → TRAP.
  - exception → TRAP.
  - dec_system with ECALL or EBREAK → TRAP; MRET → RETURN; WFI → WFINTR.
  - Any dec_mc_sel bit set: if mc_rdy of the selected unit is high the same cycle, stay in STEADY (zero-wait completion); otherwise go to MC and latch mc_idx.
  - Otherwise stay in STEADY.
- MC → STEADY on mc_rdy[mc_idx]. WFINTR → TRAP on core_interrupt. TRAP → JUMP. RETURN → JUMP. JUMP → STEADY on trap_jump.
- activate_trap and return_trap are combinational from state, so each is high for exactly 1 cycle per entry.
- exec_pc <= decode_pc when decode_vld & decode_rdy.
- instret <= (decode_vld & decode_rdy) | (dec_system & trap_jump). It is a 1-cycle registered pulse.
- Trap event detection:
  - now = exception | trap_jump | core_interrupt.
  - A flop evt_q <= now.
  - pulse = now & ~evt_q; the rising edge only, so a sustained condition logs once.
  - On pulse, push exec_pc as it is before any same-cycle update.
- Log FIFO:
  - trap_log_pc is the head entry and is valid while trap_log_vld.
  - Pop on trap_log_vld & trap_log_rdy.
  - Push when full with no pop: drop the new entry and set trap_log_ovf.
  - Push and pop together when full: both take effect, count unchanged.
  - Push and pop together when empty: push only, since vld=0.
  - Pointers wrap modulo TRAP_LOG_DEPTH. Count is clog2(DEPTH)+1 bits.
  - trap_log_ovf stays set until trap_log_clr. If clr coincides with a new overflow, set wins.
- Reset (asynchronous, any time, including mid-MC or in JUMP):
  - state=STEADY, mc_idx=0, exec_pc=0, instret=0, evt_q=0.
  - FIFO empty, trap_log_vld=0, trap_log_ovf=0, trap_log_pc=0.
  - Combinational outputs follow from that reset state.

Decomposition:
- kronos_types gains the ex_state_e enum (6 states, 3 bits). It reuses the existing sysop constants (ECALL, EBREAK, MRET, WFI).
- Sub-module kronos_trap_log_fifo (parametrised WIDTH=32, DEPTH) holds the FIFO, overflow flag and clear logic.
- The sequencer holds the FSM, ready/valid gating and instret.

Test Plan:
- NUM_MC=3; dec_mc_sel=3'b010 with mc_rdy[1] asserted 3 cycles later → mc_vld[1] high for 4 cycles; state STEADY→MC→STEADY; decode_rdy high for 1 cycle; instret pulses 1 cycle later.
- dec_mc_sel=3'b001 with mc_rdy[0] high the same cycle → zero-wait path: state stays STEADY and decode_rdy=1 that cycle.
- FENCE with stbuf_empty=0 for 5 cycles → decode_rdy=0 for those 5 cycles, then 1 on the cycle stbuf_empty=1. With FENCE_DRAIN=0 → decode_rdy=1 immediately.
- ECALL at decode_pc=0x100 → activate_trap for 1 cycle, then JUMP; trap_jump → STEADY and instret=1; log head=exec_pc of the prior instruction; trap_log_vld=1.
- WFI, then core_interrupt after 10 cycles → WFINTR held 10 cycles, then TRAP and JUMP; exactly one log push despite the interrupt level staying high.
- DEPTH=4: 5 rising trap events with no pop → 4 entries retained in order; trap_log_ovf=1. Simultaneous pop+push at full keeps count=4. trap_log_clr clears ovf. Reset asserted mid-MC → state=STEADY, FIFO empty.

Source files
------------

// File: rtl/kronos_ex_sequencer_pkg.sv
// Shared types for the Kronos execute-stage sequencer.
// Holds the sequencer state enum and the system-op codes.
package kronos_ex_sequencer_pkg;

    typedef enum logic [2:0] {
        STEADY,
        MC,
        TRAP,
        RETURN,
        WFINTR,
        JUMP
    } ex_state_e;

    localparam logic [1:0] ECALL  = 2'b00;
    localparam logic [1:0] EBREAK = 2'b01;
    localparam logic [1:0] MRET   = 2'b10;
    localparam logic [1:0] WFI    = 2'b11;

endpackage

// File: rtl/kronos_ex_sequencer_if.sv
// Decode-side / functional-unit bundle of the execute sequencer.
// master: decode stage and units; slave: the sequencer itself.
interface kronos_ex_sequencer_if #(
    parameter int NUM_MC = 3
);
    logic              decode_vld;
    logic              decode_rdy;
    logic [31:0]       decode_pc;
    logic              dec_basic;
    logic              dec_fence;
    logic [NUM_MC-1:0] dec_mc_sel;
    logic              dec_system;
    logic [1:0]        dec_sysop;
    logic              exception;
    logic              core_interrupt;
    logic              stbuf_empty;
    logic [NUM_MC-1:0] mc_vld;
    logic [NUM_MC-1:0] mc_rdy;
    logic              instr_vld;
    logic              activate_trap;
    logic              return_trap;
    logic              trap_jump;

    modport master (
        output decode_vld, decode_pc, dec_basic, dec_fence,
        output dec_mc_sel, dec_system, dec_sysop, exception,
        output core_interrupt, stbuf_empty, mc_rdy, trap_jump,
        input  decode_rdy, mc_vld, instr_vld,
        input  activate_trap, return_trap
    );

    modport slave (
        input  decode_vld, decode_pc, dec_basic, dec_fence,
        input  dec_mc_sel, dec_system, dec_sysop, exception,
        input  core_interrupt, stbuf_empty, mc_rdy, trap_jump,
        output decode_rdy, mc_vld, instr_vld,
        output activate_trap, return_trap
    );
endinterface

// File: rtl/kronos_ex_sequencer_trap_log.sv
// kronos_trap_log_fifo: trap-PC log with sticky overflow flag.
// push_i/din_i in; vld_o/rdy_i/dout_o head pop; ovf_o cleared by clr_i.
module kronos_trap_log_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstz,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             rdy_i,
    input  logic             clr_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] dout_o,
    output logic             ovf_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q;
    logic             full, pop, wr_en, drop;

    assign full   = (cnt_q == CW'(DEPTH));
    assign vld_o  = (cnt_q != '0);
    assign pop    = vld_o & rdy_i;
    // a pop in the same cycle frees the slot the push needs
    assign wr_en  = push_i & (~full | pop);
    assign drop   = push_i & full & ~pop;
    assign cnt_d  = cnt_q + CW'(wr_en) - CW'(pop);
    assign dout_o = vld_o ? mem_q[rd_q] : '0;
    assign ovf_o  = ovf_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (pop)   rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
            // a fresh overflow beats a simultaneous clear
            ovf_q <= drop | (ovf_q & ~clr_i);
        end
    end
endmodule

// File: rtl/kronos_ex_sequencer.sv
// Execute-stage sequencer: gates issue, sequences multi-cycle units,
// traps, returns and WFI. bus: decode/unit bundle; trap_log_*: PC log.
module kronos_ex_sequencer
    import kronos_ex_sequencer_pkg::*;
#(
    parameter int NUM_MC         = 3,
    parameter bit FENCE_DRAIN    = 1'b1,
    parameter int TRAP_LOG_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rstz,
    kronos_ex_sequencer_if.slave bus,
    output logic        instret,
    output logic [31:0] exec_pc,
    output logic        trap_log_vld,
    input  logic        trap_log_rdy,
    output logic [31:0] trap_log_pc,
    output logic        trap_log_ovf,
    input  logic        trap_log_clr
);
    localparam int IW = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;

    ex_state_e         state_q, state_d;
    logic [IW-1:0]     mc_idx_q, mc_idx_d, sel_idx;
    logic [NUM_MC-1:0] mc_vld;
    logic [31:0]       exec_pc_q;
    logic              instret_q, evt_q;
    logic              sel_any, sel_rdy, instr_vld, fence_hold;
    logic              accept, trap_now, trap_push;

    // lowest set select bit wins
    always_comb begin
        sel_any = 1'b0;
        sel_idx = '0;
        for (int i = NUM_MC - 1; i >= 0; i--) begin
            if (bus.dec_mc_sel[i]) begin
                sel_any = 1'b1;
                sel_idx = IW'(i);
            end
        end
    end

    assign sel_rdy   = bus.mc_rdy[sel_idx];
    assign instr_vld = bus.decode_vld & (state_q == STEADY)
                     & ~bus.exception & ~bus.core_interrupt;
    assign fence_hold = FENCE_DRAIN & bus.dec_fence
                      & instr_vld & ~bus.stbuf_empty;

    always_comb begin
        mc_vld = '0;
        for (int i = 0; i < NUM_MC; i++) begin
            mc_vld[i] = (instr_vld & sel_any & (sel_idx == IW'(i)))
                      | ((state_q == MC) & (mc_idx_q == IW'(i)));
        end
    end

    assign bus.mc_vld        = mc_vld;
    assign bus.instr_vld     = instr_vld;
    assign bus.decode_rdy    = (instr_vld & bus.dec_basic & ~fence_hold)
                             | (|(mc_vld & bus.mc_rdy));
    assign bus.activate_trap = (state_q == TRAP);
    assign bus.return_trap   = (state_q == RETURN);

    always_comb begin
        state_d  = state_q;
        mc_idx_d = mc_idx_q;
        unique case (state_q)
            STEADY: begin
                if (bus.decode_vld) begin
                    if (bus.core_interrupt || bus.exception) begin
                        state_d = TRAP;
                    end else if (bus.dec_system) begin
                        unique case (bus.dec_sysop)
                            ECALL, EBREAK: state_d = TRAP;
                            MRET:          state_d = RETURN;
                            default:       state_d = WFINTR;
                        endcase
                    end else if (sel_any && !sel_rdy) begin
                        state_d  = MC;
                        mc_idx_d = sel_idx;
                    end
                end
            end
            MC:      if (bus.mc_rdy[mc_idx_q]) state_d = STEADY;
            WFINTR:  if (bus.core_interrupt) state_d = TRAP;
            TRAP:    state_d = JUMP;
            RETURN:  state_d = JUMP;
            JUMP:    if (bus.trap_jump) state_d = STEADY;
            default: state_d = STEADY;
        endcase
    end

    assign accept    = bus.decode_vld & bus.decode_rdy;
    assign trap_now  = bus.exception | bus.trap_jump | bus.core_interrupt;
    // log only the rising edge of a trap condition
    assign trap_push = trap_now & ~evt_q;

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q   <= STEADY;
            mc_idx_q  <= '0;
            exec_pc_q <= '0;
            instret_q <= 1'b0;
            evt_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mc_idx_q  <= mc_idx_d;
            if (accept) exec_pc_q <= bus.decode_pc;
            instret_q <= accept | (bus.dec_system & bus.trap_jump);
            evt_q     <= trap_now;
        end
    end

    assign instret = instret_q;
    assign exec_pc = exec_pc_q;

    // logs the PC held before this cycle's update
    kronos_trap_log_fifo #(
        .WIDTH (32),
        .DEPTH (TRAP_LOG_DEPTH)
    ) u_log (
        .clk    (clk),
        .rstz   (rstz),
        .push_i (trap_push),
        .din_i  (exec_pc_q),
        .rdy_i  (trap_log_rdy),
        .clr_i  (trap_log_clr),
        .vld_o  (trap_log_vld),
        .dout_o (trap_log_pc),
        .ovf_o  (trap_log_ovf)
    );
endmodule
